// File: rtl/cvxif_arb_pkg.sv
// cvxif_arb_pkg: tag-table entry type and free-tag priority encoder for the CV-X-IF issue arbiter
package cvxif_arb_pkg;
  localparam int unsigned MaxPortW = 8;
  localparam int unsigned MaxIdW = 16;
  localparam int unsigned MaxTags = 64;
  typedef struct packed {
    logic in_use;
    logic [MaxPortW-1:0] port;
    logic [MaxIdW-1:0] id;
  } tag_entry_t;
  // Returns the lowest clear index below n, or n when every tag is in use.
  function automatic int unsigned lowest_free(input logic [MaxTags-1:0] used, input int unsigned n);
    int unsigned r;
    r = n;
    for (int unsigned i = 0; i < MaxTags; i++)
      if (i < n && !used[i] && r == n) r = i;
    return r;
  endfunction
endpackage

// File: rtl/cvxif_arb_rr.sv
// cvxif_arb_rr: round-robin arbiter with a hold-grant lock, one-hot plus index grant
module cvxif_arb_rr #(
  parameter int unsigned N = 2,
  localparam int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  input  logic         lock_i,
  input  logic [W-1:0] lock_idx_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o,
  output logic         valid_o
);
  logic [W:0] sum, j;
  always_comb begin
    idx_o = lock_idx_i;
    valid_o = lock_i & req_i[lock_idx_i];
    sum = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_i} + (W + 1)'(k);
      j = (sum >= (W + 1)'(N)) ? sum - (W + 1)'(N) : sum;
      if (!lock_i && req_i[j[W-1:0]]) begin
        idx_o = j[W-1:0];
        valid_o = 1'b1;
      end
    end
  end
  assign gnt_o = valid_o ? (N'(1) << idx_o) : '0;
endmodule

// File: rtl/cvxif_issue_arbiter.sv
// cvxif_issue_arbiter: shares one CV-X-IF coprocessor among NrPorts cores with ID-to-tag renaming
module cvxif_issue_arbiter
  import cvxif_arb_pkg::*;
#(
  parameter int unsigned NrPorts = 2,
  parameter int unsigned IdWidth = 3,
  parameter int unsigned InstrWidth = 32,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned NrTags = 4,
  localparam int unsigned TagWidth = $clog2(NrTags)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NrPorts-1:0]                   req_valid_i,
  output logic [NrPorts-1:0]                   req_ready_o,
  input  logic [NrPorts-1:0][InstrWidth-1:0]   req_instr_i,
  input  logic [NrPorts-1:0][IdWidth-1:0]      req_id_i,
  output logic                                 cop_valid_o,
  input  logic                                 cop_ready_i,
  output logic [InstrWidth-1:0]                cop_instr_o,
  output logic [TagWidth-1:0]                  cop_tag_o,
  input  logic                                 cop_res_valid_i,
  output logic                                 cop_res_ready_o,
  input  logic [TagWidth-1:0]                  cop_res_tag_i,
  input  logic [DataWidth-1:0]                 cop_res_data_i,
  output logic [NrPorts-1:0]                   res_valid_o,
  input  logic [NrPorts-1:0]                   res_ready_i,
  output logic [IdWidth-1:0]                   res_id_o,
  output logic [DataWidth-1:0]                 res_data_o,
  output logic                                 busy_o,
  output logic                                 err_o
);
  localparam int unsigned PortW = (NrPorts > 1) ? $clog2(NrPorts) : 1;
  tag_entry_t [NrTags-1:0] tab_q, tab_d;
  logic [PortW-1:0] rr_q, rr_d, lock_port_q, lock_port_d, gnt_idx, res_port;
  logic [TagWidth-1:0] lock_tag_q, lock_tag_d, free_tag;
  logic lock_q, lock_d, err_q, err_d, gnt_valid, tag_free, issue_hs, res_hit, res_hs;
  logic [NrTags-1:0] in_use;
  logic [NrPorts-1:0] gnt;
  tag_entry_t res_entry;
  int unsigned free_idx;
  logic unused_bits;
  always_comb begin
    in_use = '0;
    for (int t = 0; t < NrTags; t++) in_use[t] = tab_q[t].in_use;
  end
  assign free_idx = lowest_free(MaxTags'(in_use), NrTags);
  assign tag_free = free_idx < NrTags;
  assign free_tag = TagWidth'(free_idx);
  cvxif_arb_rr #(.N(NrPorts)) u_rr (
    .req_i      (req_valid_i),
    .ptr_i      (rr_q),
    .lock_i     (lock_q),
    .lock_idx_i (lock_port_q),
    .gnt_o      (gnt),
    .idx_o      (gnt_idx),
    .valid_o    (gnt_valid)
  );
  // A locked grant keeps its tag; that tag cannot be freed because it was never allocated.
  assign cop_valid_o = gnt_valid & (lock_q | tag_free);
  assign cop_instr_o = req_instr_i[gnt_idx];
  assign cop_tag_o = lock_q ? lock_tag_q : free_tag;
  assign req_ready_o = (cop_valid_o && cop_ready_i) ? gnt : '0;
  assign issue_hs = cop_valid_o & cop_ready_i;
  assign res_entry = tab_q[cop_res_tag_i];
  assign res_port = res_entry.port[PortW-1:0];
  assign res_hit = cop_res_valid_i & res_entry.in_use;
  assign res_valid_o = res_hit ? (NrPorts'(1) << res_port) : '0;
  assign cop_res_ready_o = !res_hit | res_ready_i[res_port];
  assign res_hs = res_hit & res_ready_i[res_port];
  assign res_id_o = res_entry.id[IdWidth-1:0];
  assign res_data_o = cop_res_data_i;
  assign busy_o = |in_use;
  assign err_o = err_q;
  assign unused_bits = ^{res_entry.port, res_entry.id};
  always_comb begin
    tab_d = tab_q;
    if (res_hs) tab_d[cop_res_tag_i].in_use = 1'b0;
    if (issue_hs) tab_d[cop_tag_o] = '{in_use: 1'b1, port: MaxPortW'(gnt_idx), id: MaxIdW'(req_id_i[gnt_idx])};
    rr_d = !issue_hs ? rr_q : (gnt_idx == PortW'(NrPorts - 1)) ? '0 : gnt_idx + PortW'(1);
    lock_d = cop_valid_o & ~cop_ready_i;
    lock_port_d = gnt_idx;
    lock_tag_d = cop_tag_o;
    err_d = err_q | (cop_res_valid_i & ~res_entry.in_use);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tab_q <= '0;
      rr_q <= '0;
      lock_q <= 1'b0;
      lock_port_q <= '0;
      lock_tag_q <= '0;
      err_q <= 1'b0;
    end else begin
      tab_q <= tab_d;
      rr_q <= rr_d;
      lock_q <= lock_d;
      lock_port_q <= lock_port_d;
      lock_tag_q <= lock_tag_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_cvxif_issue_arbiter.sv
// tb_cvxif_issue_arbiter: directed plus randomized checks against a tag-table reference model
module tb_cvxif_issue_arbiter;
  localparam int NP = 2, IW = 3, XW = 32, DW = 64, NT = 4, TW = 2;
  logic clk = 1'b0, rst;
  logic [NP-1:0] req_valid, req_ready, res_valid, res_ready;
  logic [NP-1:0][XW-1:0] req_instr;
  logic [NP-1:0][IW-1:0] req_id;
  logic cop_valid, cop_ready, cop_res_valid, cop_res_ready, busy, err;
  logic [XW-1:0] cop_instr;
  logic [TW-1:0] cop_tag, cop_res_tag;
  logic [DW-1:0] cop_res_data, res_data;
  logic [IW-1:0] res_id;
  always #5 clk = ~clk;
  cvxif_issue_arbiter #(.NrPorts(NP), .IdWidth(IW), .InstrWidth(XW), .DataWidth(DW), .NrTags(NT)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_instr_i(req_instr), .req_id_i(req_id),
    .cop_valid_o(cop_valid), .cop_ready_i(cop_ready), .cop_instr_o(cop_instr), .cop_tag_o(cop_tag),
    .cop_res_valid_i(cop_res_valid), .cop_res_ready_o(cop_res_ready), .cop_res_tag_i(cop_res_tag),
    .cop_res_data_i(cop_res_data), .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_id_o(res_id), .res_data_o(res_data), .busy_o(busy), .err_o(err)
  );
  int n_cmp = 0, n_err = 0;
  bit m_used[NT];
  int m_port[NT], m_id[NT];
  int m_rr, m_lport, m_ltag;
  bit m_lock, m_err;
  bit e_v = 0, e_hit = 0;
  int e_g = 0, e_tag = 0;
  bit held[NP];
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    req_valid = '0; req_instr = '0; req_id = '0; cop_ready = 0;
    cop_res_valid = 0; cop_res_tag = '0; cop_res_data = '0; res_ready = '0;
  endtask
  task automatic model_reset();
    for (int t = 0; t < NT; t++) begin m_used[t] = 0; m_port[t] = 0; m_id[t] = 0; end
    m_rr = 0; m_lock = 0; m_lport = 0; m_ltag = 0; m_err = 0;
  endtask
  // Expected outputs from the arbitration rules applied to the model's tag table.
  task automatic check_cycle();
    int free, t;
    bit any;
    #1;
    free = -1; any = 0;
    for (int i = NT - 1; i >= 0; i--) if (!m_used[i]) free = i;
    for (int i = 0; i < NT; i++) any |= m_used[i];
    e_v = 0; e_g = 0; e_tag = 0;
    if (m_lock) begin
      e_g = m_lport; e_v = req_valid[m_lport]; e_tag = m_ltag;
    end else if (free >= 0) begin
      for (int k = 0; k < NP; k++)
        if (!e_v && req_valid[(m_rr + k) % NP]) begin e_v = 1; e_g = (m_rr + k) % NP; e_tag = free; end
    end
    chk("cop_valid", cop_valid, e_v);
    chk("req_ready", req_ready, (e_v && cop_ready) ? (1 << e_g) : 0);
    if (e_v) begin
      chk("cop_instr", cop_instr, req_instr[e_g]);
      chk("cop_tag", cop_tag, e_tag);
    end
    t = cop_res_tag;
    e_hit = cop_res_valid && m_used[t];
    chk("res_valid", res_valid, e_hit ? (1 << m_port[t]) : 0);
    chk("cop_res_ready", cop_res_ready, e_hit ? res_ready[m_port[t]] : 1);
    if (e_hit) begin
      chk("res_id", res_id, m_id[t]);
      chk("res_data", res_data, cop_res_data);
    end
    chk("busy", busy, any);
    chk("err", err, m_err);
  endtask
  task automatic tick();
    int t;
    @(posedge clk);
    t = cop_res_tag;
    if (rst) model_reset();
    else begin
      if (cop_res_valid && !m_used[t]) m_err = 1;
      if (e_hit && res_ready[m_port[t]]) m_used[t] = 0;
      if (e_v && cop_ready) begin
        m_used[e_tag] = 1; m_port[e_tag] = e_g; m_id[e_tag] = req_id[e_g]; m_rr = (e_g + 1) % NP;
      end
      m_lock = e_v && !cop_ready; m_lport = e_g; m_ltag = e_tag;
    end
    for (int p = 0; p < NP; p++) held[p] = !rst && req_valid[p] && !(e_v && cop_ready && e_g == p);
    @(negedge clk);
  endtask
  task automatic apply_reset();
    idle(); rst = 1; tick(); rst = 0;
  endtask
  initial begin
    model_reset();
    apply_reset();
    // reset state and single request round trip
    check_cycle();
    chk("rst_cop_valid", cop_valid, 0); chk("rst_req_ready", req_ready, 0);
    chk("rst_res_valid", res_valid, 0); chk("rst_busy", busy, 0); chk("rst_err", err, 0);
    tick();
    req_valid = 2'b01; req_instr[0] = 32'h0000_000B; req_id[0] = 3'd5; cop_ready = 1;
    check_cycle(); chk("t1_tag", cop_tag, 0); chk("t1_ready", req_ready, 2'b01); tick();
    idle(); check_cycle(); chk("t1_busy", busy, 1); tick();
    cop_res_valid = 1; cop_res_tag = 0; cop_res_data = 64'hDEAD; res_ready = 2'b11;
    check_cycle(); chk("t1_res_valid", res_valid, 2'b01); chk("t1_res_id", res_id, 5);
    chk("t1_res_data", res_data, 64'hDEAD); tick();
    idle(); check_cycle(); chk("t1_busy_fall", busy, 0); tick();
    // fairness and tag exhaustion
    apply_reset();
    req_valid = 2'b11; cop_ready = 1;
    req_instr[0] = 32'h100; req_instr[1] = 32'h201; req_id[0] = 3'd0; req_id[1] = 3'd1;
    for (int k = 0; k < 4; k++) begin
      check_cycle(); chk("t2_ready", req_ready, 1 << (k % 2)); chk("t2_tag", cop_tag, k); tick();
      req_id[k % 2] = 3'(k + 2); req_instr[k % 2] = 32'h100 * (k % 2 + 1) + 32'(k + 2);
    end
    check_cycle(); chk("t2_stall_valid", cop_valid, 0); chk("t2_stall_ready", req_ready, 0); tick();
    // free tag 1 while full: no grant this cycle, tag 1 next cycle
    cop_res_valid = 1; cop_res_tag = 1; cop_res_data = 64'h1111; res_ready = 2'b11;
    check_cycle(); chk("t5_nogrant", cop_valid, 0); chk("t5_res_valid", res_valid, 2'b10); tick();
    cop_res_valid = 0;
    check_cycle(); chk("t5_grant", cop_valid, 1); chk("t5_tag", cop_tag, 1); chk("t5_ready", req_ready, 2'b01); tick();
    // out-of-order results with result backpressure
    idle();
    cop_res_valid = 1; cop_res_tag = 2; cop_res_data = 64'h2222;
    for (int k = 0; k < 2; k++) begin
      check_cycle(); chk("t4_hold_ready", cop_res_ready, 0); chk("t4_hold_valid", res_valid, 2'b01);
      chk("t4_hold_busy", busy, 1); tick();
    end
    res_ready = 2'b11;
    check_cycle(); chk("t4_tag2", res_valid, 2'b01); chk("t4_tag2_ready", cop_res_ready, 1); tick();
    cop_res_tag = 0; cop_res_data = 64'h0; check_cycle(); chk("t4_tag0", res_valid, 2'b01); tick();
    cop_res_tag = 1; cop_res_data = 64'h1; check_cycle(); chk("t4_tag1", res_valid, 2'b01); tick();
    cop_res_tag = 3; cop_res_data = 64'h3; check_cycle(); chk("t4_tag3", res_valid, 2'b10); tick();
    idle(); check_cycle(); chk("t4_idle_busy", busy, 0); tick();
    // issue backpressure holds grant and tag on port 1
    req_valid = 2'b11; req_instr[0] = 32'hA0; req_instr[1] = 32'hA1; req_id[0] = 3'd6; req_id[1] = 3'd7;
    for (int k = 0; k < 3; k++) begin
      check_cycle(); chk("t3_valid", cop_valid, 1); chk("t3_instr", cop_instr, 32'hA1);
      chk("t3_tag", cop_tag, 0); chk("t3_ready", req_ready, 0); tick();
    end
    cop_ready = 1; check_cycle(); chk("t3_hs", req_ready, 2'b10); tick();
    req_valid = 2'b01; check_cycle(); chk("t3_port0", req_ready, 2'b01); chk("t3_port0_tag", cop_tag, 1); tick();
    // spurious result on a free tag
    idle(); cop_res_valid = 1; cop_res_tag = 3;
    check_cycle(); chk("t6_ready", cop_res_ready, 1); chk("t6_no_valid", res_valid, 0); tick();
    idle(); check_cycle(); chk("t6_err", err, 1); tick();
    check_cycle(); chk("t6_err_sticky", err, 1); tick();
    apply_reset(); check_cycle(); chk("t6_err_clr", err, 0); tick();
    // randomized traffic with periodic reset
    for (int i = 0; i < 600; i++) begin
      for (int p = 0; p < NP; p++)
        if (!held[p]) begin
          req_valid[p] = 1'($urandom_range(0, 1)); req_instr[p] = $urandom; req_id[p] = 3'($urandom);
        end
      cop_ready = ($urandom_range(0, 3) != 0);
      cop_res_valid = 1'($urandom_range(0, 1)); cop_res_tag = 2'($urandom);
      cop_res_data = {$urandom, $urandom}; res_ready = 2'($urandom);
      rst = (i % 150 == 149);
      check_cycle(); tick();
    end
    rst = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
